// File: rtl/median_filter_top.sv
// ---------------------------------------------------------------------------
// median_filter_top
//   Streaming 3x3 median filter for raster-order grayscale pixels, one pixel
//   per clock with no handshake. Two line-buffer RAMs each delay the stream by
//   exactly IMG_WIDTH samples. A 3x3 window register array feeds a 9-input
//   median selector, and the result is registered onto DATA_OUT.
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous reset, active low (0 = in reset)
//   DATA_IN    pixel captured on every rising edge while reset = 1
//   DATA_OUT   registered median of the previous cycle's window
//   Valid_OUT  high once DATA_OUT is the median of a fully loaded window
// ---------------------------------------------------------------------------
module median_filter_top #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  Valid_OUT
);

  localparam int PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int FILL  = 2 * IMG_WIDTH + 2;
  localparam int CNT_W = $clog2(FILL + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILL);

  // -------------------------------------------------------------------------
  // Line buffers. Both RAMs share one circular pointer. The slot at ptr_q was
  // written exactly IMG_WIDTH edges ago, so reading before overwriting gives
  // a W-sample delay with no gap cycle at the wrap. RAM contents are not
  // reset; anything stale is masked by Valid_OUT.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd;
  logic [DATA_WIDTH-1:0] lb2_rd;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  assign lb1_rd = lb1_mem[ptr_q];
  assign lb2_rd = lb2_mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q + PTR_W'(1);
    if (ptr_q == PTR_LAST) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lb1_mem[ptr_q] <= DATA_IN;
      lb2_mem[ptr_q] <= lb1_rd;
    end
  end

  // -------------------------------------------------------------------------
  // Window registers. Index 0..2 = top row, 3..5 = middle, 6..8 = bottom;
  // within a row the lowest index is the oldest pixel.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];

  always_comb begin
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = lb2_rd;
    win_d[3] = win_q[4];
    win_d[4] = win_q[5];
    win_d[5] = lb1_rd;
    win_d[6] = win_q[7];
    win_d[7] = win_q[8];
    win_d[8] = DATA_IN;
  end

  // -------------------------------------------------------------------------
  // Median selection by ranking. Each element's rank is the number of other
  // elements that are smaller, or equal but at a lower index. The index
  // tie-break gives every element a distinct rank 0..8, so exactly one
  // element has rank 4 and it is the 5th smallest, with duplicates counted
  // individually.
  // -------------------------------------------------------------------------
  logic [3:0]            rank [9];
  logic [DATA_WIDTH-1:0] med;

  always_comb begin
    med = '0;
    for (int i = 0; i < 9; i++) begin
      rank[i] = '0;
      for (int j = 0; j < 9; j++) begin
        if (j != i) begin
          if ((win_q[j] < win_q[i]) || ((win_q[j] == win_q[i]) && (j < i))) begin
            rank[i] = rank[i] + 4'd1;
          end
        end
      end
      if (rank[i] == 4'd4) begin
        med = win_q[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Fill tracking. Before edge k, cnt_q holds min(k, 2W+2). This means
  // full_q after edge k is set exactly when the window holds real data
  // (k >= 2W+2). Valid_OUT follows one edge later, aligned with DATA_OUT.
  // The counter saturates, so Valid_OUT never drops until reset.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  always_comb begin
    full_d  = (cnt_q == CNT_FULL);
    cnt_d   = full_d ? cnt_q : cnt_q + CNT_W'(1);
    data_d  = med;
    valid_d = full_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign DATA_OUT  = data_q;
  assign Valid_OUT = valid_q;

endmodule

// File: tb/tb_median_filter_top.sv
// ---------------------------------------------------------------------------
// tb_median_filter_top
//   Directed bench for median_filter_top (W = 256). Keeps a history of the
//   pixels driven since the last reset, and computes each expected median by
//   sorting the 9 window pixels. Some steps also carry a hand-computed
//   expected value.
// ---------------------------------------------------------------------------
module tb_median_filter_top;

  localparam int DW         = 8;
  localparam int W          = 256;
  localparam int FILL_EDGES = 2 * W + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] DATA_OUT;
  logic          Valid_OUT;

  int tests = 0;
  int fails = 0;
  int n     = 0;
  logic [7:0] hist [1024];

  median_filter_top #(.DATA_WIDTH(DW), .IMG_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .Valid_OUT(Valid_OUT)
  );

  always #5 clk = ~clk;

  // Median of the window after edge kk, taken from the pixel history.
  function automatic logic [7:0] model_med(input int kk);
    logic [7:0] v [9];
    logic [7:0] t;
    int base;
    for (int r = 0; r < 3; r++) begin
      base = kk - (2 - r) * W;
      for (int c = 0; c < 3; c++) begin
        v[r * 3 + c] = hist[(base - 2 + c) & 1023];
      end
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8 - a; b++) begin
        if (v[b] > v[b + 1]) begin
          t        = v[b];
          v[b]     = v[b + 1];
          v[b + 1] = t;
        end
      end
    end
    return v[4];
  endfunction

  // Drive one pixel, clock it in, then check the outputs, which reflect the
  // window after the previous edge.
  task automatic step(input logic [7:0] pix, input int hand);
    logic       exp_v;
    logic [7:0] exp_d;
    exp_v = (n >= FILL_EDGES);
    exp_d = exp_v ? model_med(n - 1) : 8'd0;
    DATA_IN = pix;
    @(posedge clk);
    #1;
    tests++;
    assert (Valid_OUT === exp_v)
      else begin fails++; $error("FAIL valid edge=%0d got=%0b exp=%0b", n, Valid_OUT, exp_v); end
    if (exp_v) begin
      tests++;
      assert (DATA_OUT === exp_d)
        else begin fails++; $error("FAIL model_data edge=%0d got=%0d exp=%0d", n, DATA_OUT, exp_d); end
    end
    if (hand >= 0) begin
      tests++;
      assert (DATA_OUT === hand[7:0])
        else begin fails++; $error("FAIL hand_data edge=%0d got=%0d exp=%0d", n, DATA_OUT, hand); end
    end
    hist[n & 1023] = pix;
    n++;
  endtask

  // Asynchronous reset pulse asserted mid-cycle and held across one edge.
  task automatic reset_pulse();
    #1;
    reset = 1'b0;
    #1;
    tests++;
    assert (DATA_OUT === 8'd0)
      else begin fails++; $error("FAIL rst_data got=%0d exp=0", DATA_OUT); end
    tests++;
    assert (Valid_OUT === 1'b0)
      else begin fails++; $error("FAIL rst_valid got=%0b exp=0", Valid_OUT); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    n = 0;
  endtask

  logic [7:0] pat [1000];
  int hand;
  int kk;

  initial begin
    reset   = 1'b1;
    DATA_IN = '0;
    #1 reset = 1'b0;
    #1;
    tests++;
    assert (DATA_OUT === 8'd0)
      else begin fails++; $error("FAIL init_data got=%0d exp=0", DATA_OUT); end
    tests++;
    assert (Valid_OUT === 1'b0)
      else begin fails++; $error("FAIL init_valid got=%0b exp=0", Valid_OUT); end
    #10 reset = 1'b1;

    // Constant 100: valid rises exactly at edge 515.
    for (int e = 0; e < 600; e++) begin
      step(8'd100, (e >= 515) ? 100 : -1);
      if (e == 514) begin
        tests++;
        assert (Valid_OUT === 1'b0)
          else begin fails++; $error("FAIL valid_514 got=%0b exp=0", Valid_OUT); end
      end
      if (e == 515) begin
        tests++;
        assert (Valid_OUT === 1'b1)
          else begin fails++; $error("FAIL valid_515 got=%0b exp=1", Valid_OUT); end
      end
    end

    // Single bright impulse in black is removed.
    reset_pulse();
    for (int e = 0; e < 1600; e++) begin
      step((e == 1000) ? 8'd255 : 8'd0, (e >= 515) ? 0 : -1);
    end

    // Single dark impulse in white is removed.
    reset_pulse();
    for (int e = 0; e < 1600; e++) begin
      step((e == 1000) ? 8'd0 : 8'd255, (e >= 515) ? 255 : -1);
    end

    // Hand-built windows on a zero background.
    for (int i = 0; i < 1000; i++) pat[i] = 8'd0;
    // k=524: nine distinct values, median 5.
    pat[10]  = 8'd2; pat[11]  = 8'd6; pat[12]  = 8'd4;
    pat[266] = 8'd7; pat[267] = 8'd3; pat[268] = 8'd8;
    pat[522] = 8'd9; pat[523] = 8'd1; pat[524] = 8'd5;
    // k=600: same values permuted, median 5.
    pat[86]  = 8'd3; pat[87]  = 8'd7; pat[88]  = 8'd6;
    pat[342] = 8'd5; pat[343] = 8'd9; pat[344] = 8'd1;
    pat[598] = 8'd4; pat[599] = 8'd8; pat[600] = 8'd2;
    // k=700: five 255s and four 0s, median 255.
    pat[186] = 8'd255; pat[188] = 8'd255; pat[443] = 8'd255;
    pat[698] = 8'd255; pat[700] = 8'd255;
    // k=800: four 255s and five 0s, median 0.
    pat[286] = 8'd255; pat[287] = 8'd255; pat[544] = 8'd255; pat[799] = 8'd255;
    reset_pulse();
    for (int e = 0; e < 1000; e++) begin
      hand = -1;
      if (e == 525) hand = 5;
      if (e == 601) hand = 5;
      if (e == 701) hand = 255;
      if (e == 801) hand = 0;
      step(pat[e], hand);
    end

    // Ramp: interior columns give (k-W-1) mod 256; wrap columns use the model.
    reset_pulse();
    for (int e = 0; e < 1400; e++) begin
      kk   = e - 1;
      hand = -1;
      if (kk >= 2 * W + 2 && (kk % W) >= 2) hand = (kk - W - 1) % 256;
      step(8'(e % 256), hand);
    end

    // Long random stream, then a mid-stream reset at edge 40000 and refill.
    reset_pulse();
    for (int e = 0; e < 40000; e++) begin
      step(8'($urandom_range(0, 255)), -1);
    end
    reset_pulse();
    for (int e = 0; e < 600; e++) begin
      step(8'($urandom_range(0, 255)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
